// File: rtl/multicycle_adder_module.sv
// multicycle_adder_module: WIDTH-bit adder that adds one CHUNK-bit slice per
// clock. start is accepted in IDLE and done pulses for one cycle.
// Optional feature macro: SIGNED_OVF_EN adds the registered signed-overflow
// output ovf.
module multicycle_adder_module #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t state, state_n;

  // The operands and the result are held as arrays of chunks, so the chunk
  // index selects a slice directly.
  logic [NCHUNK-1:0][CHUNK-1:0] op_a, op_b, sum_r;
  logic                         carry;
  logic [IDX_W-1:0]             idx;
  logic                         last;
  logic [CHUNK:0]               slice;

  assign last  = (idx == IDX_W'(NCHUNK - 1));
  assign slice = {1'b0, op_a[idx]} + {1'b0, op_b[idx]} + {{CHUNK{1'b0}}, carry};

  assign busy = (state == ADD);
  assign done = (state == DONE);
  assign sum  = sum_r;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state logic: start matters only in IDLE, DONE always returns to IDLE.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = ADD;
      ADD:     if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: operand capture on acceptance, one slice addition per ADD cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a  <= '0;
      op_b  <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      idx   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        ADD: begin
          sum_r[idx] <= slice[CHUNK-1:0];
          carry      <= slice[CHUNK];
          idx        <= idx + IDX_W'(1);
          if (last) cout <= slice[CHUNK];
        end
        default: ;
      endcase
    end
  end

`ifdef SIGNED_OVF_EN
  // Signed overflow is judged on the final slice, whose top bit is the sum MSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
    end else if (state == ADD && last) begin
      ovf <= (op_a[NCHUNK-1][CHUNK-1] == op_b[NCHUNK-1][CHUNK-1]) &&
             (slice[CHUNK-1] != op_a[NCHUNK-1][CHUNK-1]);
    end
  end
`endif

endmodule

// File: doc/multicycle_adder_module.md
# multicycle_adder_module

Parametrised, multi-cycle ripple adder that adds two WIDTH-bit operands plus carry-in using one CHUNK-bit adder slice per clock, with a start/done handshake. It is the sequential successor to the fixed 4-bit full adder. Wide adds reuse one narrow slice so area stays constant as WIDTH grows. It sits between a requester that issues one operation at a time and any consumer of a registered sum and carry.

## Interface
- WIDTH, 16, operand/sum width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per cycle. NCHUNK = WIDTH/CHUNK; the chunk counter is clog2(NCHUNK) bits, minimum 1.
- clk  input  1  single clock; all state changes on the rising edge.
- reset_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in ADD.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  (a+b+cin) mod 2^WIDTH.
- cout  output  1  bit WIDTH of a+b+cin.
- ovf  output  1  signed overflow; present only with SIGNED_OVF_EN.

## Operation
- States: IDLE, ADD, DONE.
- IDLE, start=1: latch a, b and cin into operand registers. Clear the chunk index to 0, load carry with cin, then go to ADD.
- IDLE, start=0: stay in IDLE.
- ADD: each cycle, compute {c, s} = a[i] + b[i] + carry, where a[i] and b[i] are chunk i of the latched operands.
  - Write s into sum chunk i; carry <= c; i <= i+1.
  - When i == NCHUNK-1: cout <= c, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. start is ignored in DONE.
- start in ADD or DONE is ignored. Operand inputs are don't-care except on the accepting edge.
- sum and cout hold their values from DONE until the next accepted start.
  - During ADD, sum chunks update progressively; sum is not valid while busy=1.
- CHUNK == WIDTH: ADD lasts a single cycle.
- Reset (reset_n=0, any state, including mid-ADD): immediately state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal carry and index=0. An aborted operation never produces done.

## Timing
- Edge E0 samples start=1 in IDLE; busy rises after E0.
- Edges E1..E_NCHUNK perform the chunk additions.
- After E_NCHUNK: busy=0, done=1, and sum/cout are final.
- After E_NCHUNK+1: done=0 and state=IDLE.
- Earliest next acceptance is E_NCHUNK+2. With start held high continuously, one operation completes every NCHUNK+2 cycles.
- Latency from accepting edge to done is NCHUNK edges. Example: 4 edges for WIDTH=16, CHUNK=4.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SIGNED_OVF_EN defined:
  - Port ovf exists.
  - Set at E_NCHUNK as (a[WIDTH-1]==b[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]), using the latched operands and the final sum.
  - Held with sum; cleared by reset.
- SIGNED_OVF_EN undefined: port ovf and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert reset_n=0 with no clock running -> busy=0, done=0, sum=0x0000, cout=0, ovf=0.
- WIDTH=16, CHUNK=4; start with a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0. done is high only in the cycle after the 4th edge following acceptance.
- a=0xFFFF, b=0x0001, cin=0 (carry ripples through all chunks) -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Start with a=0x1234, b=0x1111, then pulse start with a=0xFFFF during ADD -> the second pulse is ignored; sum=0x2345 and exactly one done pulse.
- Assert reset_n=0 mid-ADD (after E2) -> all outputs are 0 immediately and no done follows. After release, a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- WIDTH=4, CHUNK=4; a=0x8, b=0x8, cin=0 -> sum=0x0, cout=1, done after the 1st edge. With start held high, back-to-back results arrive every 3 cycles.
